// File: rtl/rf_wb_pkg.sv
// Shared constants, helpers and types for the register-file writeback arbiter.
package rf_wb_pkg;

   localparam int unsigned DEF_AW = 5;
   localparam int unsigned DEF_DW = 32;

   // Width of a requester index; never narrower than one bit.
   function automatic int unsigned src_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic [DEF_AW-1:0] addr;
      logic [DEF_DW-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr wins.
module rr_pick
   import rf_wb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = src_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   gnt_idx,
   output logic            any
);

   int unsigned k;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      k       = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = (32'(ptr) + i) % NREQ;
         if (!any && req[k]) begin
            gnt[k]  = 1'b1;
            gnt_idx = PW'(k);
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing one regfile write port among NREQ writeback sources.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = DEF_AW,
   parameter int unsigned DW   = DEF_DW
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NREQ-1:0]          i_req_valid,
   output logic [NREQ-1:0]          o_req_ready,
   input  logic [NREQ*AW-1:0]       i_req_addr,
   input  logic [NREQ*DW-1:0]       i_req_data,
   input  logic                     i_rf_busy,
   output logic                     o_rf_wen,
   output logic [AW-1:0]            o_rf_waddr,
   output logic [DW-1:0]            o_rf_wdata,
   output logic [src_w(NREQ)-1:0]   o_wr_src
);

   localparam int unsigned PW = src_w(NREQ);

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_nxt;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   logic            any;
   logic            xfer;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req     (i_req_valid),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   always_comb begin
      xfer        = any & ~i_rf_busy & ~i_rst;
      o_req_ready = gnt & {NREQ{~i_rf_busy & ~i_rst}};
      sel_addr    = i_req_addr[gnt_idx*AW +: AW];
      sel_data    = i_req_data[gnt_idx*DW +: DW];
      ptr_nxt     = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
   end

   // x0 requests are still accepted and captured, only the enable is suppressed.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr        <= '0;
         o_rf_wen   <= 1'b0;
         o_rf_waddr <= '0;
         o_rf_wdata <= '0;
         o_wr_src   <= '0;
      end else begin
         o_rf_wen <= xfer && (sel_addr != '0);
         if (xfer) begin
            ptr        <= ptr_nxt;
            o_rf_waddr <= sel_addr;
            o_rf_wdata <= sel_data;
            o_wr_src   <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter with two requesters.
module tb_rf_wb_arbiter;

   localparam int unsigned NREQ = 2;
   localparam int unsigned AW   = 5;
   localparam int unsigned DW   = 32;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   valid;
   logic [NREQ-1:0]   ready;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] data;
   logic              busy;
   logic              wen;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic [0:0]        src;

   int total = 0;
   int bad   = 0;

   rf_wb_arbiter #(
      .NREQ (NREQ),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (valid),
      .o_req_ready (ready),
      .i_req_addr  (addr),
      .i_req_data  (data),
      .i_rf_busy   (busy),
      .o_rf_wen    (wen),
      .o_rf_waddr  (waddr),
      .o_rf_wdata  (wdata),
      .o_wr_src    (src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
      valid = v;
      addr  = {a1, a0};
      data  = {d1, d0};
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      busy = 1'b0;
      set_req(2'b11, 5'd3, 32'h1111_1111, 5'd7, 32'h2222_2222);
      next_cycle();
      next_cycle();
      total++; if (ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", ready); end
      total++; if (wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b want=0", wen); end
      total++; if (waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d want=0", waddr); end
      total++; if (wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", wdata); end
      total++; if (src !== 1'b0) begin bad++; $display("FAIL reset_src got=%0d want=0", src); end
      total++; if (dut.ptr !== 1'b0) begin bad++; $display("FAIL reset_ptr got=%0d want=0", dut.ptr); end
      rst = 1'b0;
      set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      next_cycle();
   endtask

   task automatic test_contention();
      logic [1:0]  exp_rdy;
      logic [4:0]  exp_a;
      logic [31:0] exp_d;
      set_req(2'b11, 5'd3, 32'hAAAA_0000, 5'd7, 32'hBBBB_0001);
      for (int i = 0; i < 4; i++) begin
         exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_a   = (i % 2 == 0) ? 5'd3 : 5'd7;
         exp_d   = (i % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_0001;
         #1;
         total++; if (ready !== exp_rdy) begin bad++; $display("FAIL cont_ready[%0d] got=%b want=%b", i, ready, exp_rdy); end
         next_cycle();
         total++; if (wen !== 1'b1) begin bad++; $display("FAIL cont_wen[%0d] got=%b want=1", i, wen); end
         total++; if (waddr !== exp_a) begin bad++; $display("FAIL cont_waddr[%0d] got=%0d want=%0d", i, waddr, exp_a); end
         total++; if (wdata !== exp_d) begin bad++; $display("FAIL cont_wdata[%0d] got=%h want=%h", i, wdata, exp_d); end
         total++; if (src !== exp_rdy[1]) begin bad++; $display("FAIL cont_src[%0d] got=%0d want=%0d", i, src, exp_rdy[1]); end
      end
      set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      total++; if (dut.ptr !== 1'b0) begin bad++; $display("FAIL cont_ptr got=%0d want=0", dut.ptr); end
      next_cycle();
   endtask

   task automatic test_single();
      set_req(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0);
      #1;
      total++; if (ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", ready); end
      next_cycle();
      set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      total++; if (wen !== 1'b1) begin bad++; $display("FAIL single_wen got=%b want=1", wen); end
      total++; if (waddr !== 5'd5) begin bad++; $display("FAIL single_waddr got=%0d want=5", waddr); end
      total++; if (wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_wdata got=%h want=deadbeef", wdata); end
      total++; if (src !== 1'b0) begin bad++; $display("FAIL single_src got=%0d want=0", src); end
      next_cycle();
      total++; if (wen !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b want=0", wen); end
      total++; if (waddr !== 5'd5) begin bad++; $display("FAIL single_hold got=%0d want=5", waddr); end
      total++; if (dut.ptr !== 1'b1) begin bad++; $display("FAIL single_ptr got=%0d want=1", dut.ptr); end
   endtask

   task automatic test_busy();
      set_req(2'b10, 5'd0, 32'd0, 5'd11, 32'hCAFE_F00D);
      busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (ready !== 2'b00) begin bad++; $display("FAIL busy_ready[%0d] got=%b want=00", i, ready); end
         next_cycle();
         total++; if (wen !== 1'b0) begin bad++; $display("FAIL busy_wen[%0d] got=%b want=0", i, wen); end
         total++; if (dut.ptr !== 1'b1) begin bad++; $display("FAIL busy_ptr[%0d] got=%0d want=1", i, dut.ptr); end
      end
      busy = 1'b0;
      #1;
      total++; if (ready !== 2'b10) begin bad++; $display("FAIL busy_release_ready got=%b want=10", ready); end
      next_cycle();
      set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      total++; if (wen !== 1'b1) begin bad++; $display("FAIL busy_release_wen got=%b want=1", wen); end
      total++; if (src !== 1'b1) begin bad++; $display("FAIL busy_release_src got=%0d want=1", src); end
      total++; if (waddr !== 5'd11) begin bad++; $display("FAIL busy_release_waddr got=%0d want=11", waddr); end
      total++; if (dut.ptr !== 1'b0) begin bad++; $display("FAIL busy_release_ptr got=%0d want=0", dut.ptr); end
   endtask

   task automatic test_x0();
      set_req(2'b10, 5'd0, 32'd0, 5'd0, 32'd1);
      #1;
      total++; if (ready !== 2'b10) begin bad++; $display("FAIL x0_ready got=%b want=10", ready); end
      next_cycle();
      total++; if (wen !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b want=0", wen); end
      total++; if (wdata !== 32'd1) begin bad++; $display("FAIL x0_wdata got=%h want=1", wdata); end
      total++; if (src !== 1'b1) begin bad++; $display("FAIL x0_src got=%0d want=1", src); end
      total++; if (dut.ptr !== 1'b0) begin bad++; $display("FAIL x0_ptr got=%0d want=0", dut.ptr); end
      set_req(2'b11, 5'd4, 32'h0000_0044, 5'd9, 32'h0000_0099);
      #1;
      total++; if (ready !== 2'b01) begin bad++; $display("FAIL x0_follow_ready got=%b want=01", ready); end
      next_cycle();
      set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      total++; if (wen !== 1'b1) begin bad++; $display("FAIL x0_follow_wen got=%b want=1", wen); end
      total++; if (waddr !== 5'd4) begin bad++; $display("FAIL x0_follow_waddr got=%0d want=4", waddr); end
      total++; if (src !== 1'b0) begin bad++; $display("FAIL x0_follow_src got=%0d want=0", src); end
      total++; if (dut.ptr !== 1'b1) begin bad++; $display("FAIL x0_follow_ptr got=%0d want=1", dut.ptr); end
   endtask

   task automatic test_reset_midop();
      set_req(2'b10, 5'd0, 32'd0, 5'd12, 32'h5555_5555);
      next_cycle();
      total++; if (wen !== 1'b1) begin bad++; $display("FAIL midrst_captured got=%b want=1", wen); end
      rst = 1'b1;
      set_req(2'b11, 5'd1, 32'd1, 5'd2, 32'd2);
      #1;
      total++; if (ready !== 2'b00) begin bad++; $display("FAIL midrst_ready got=%b want=00", ready); end
      next_cycle();
      total++; if (wen !== 1'b0) begin bad++; $display("FAIL midrst_wen got=%b want=0", wen); end
      total++; if (waddr !== 5'd0) begin bad++; $display("FAIL midrst_waddr got=%0d want=0", waddr); end
      total++; if (wdata !== 32'd0) begin bad++; $display("FAIL midrst_wdata got=%h want=0", wdata); end
      total++; if (src !== 1'b0) begin bad++; $display("FAIL midrst_src got=%0d want=0", src); end
      total++; if (dut.ptr !== 1'b0) begin bad++; $display("FAIL midrst_ptr got=%0d want=0", dut.ptr); end
      rst = 1'b0;
      set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      next_cycle();
   endtask

   initial begin
      rst  = 1'b1;
      busy = 1'b0;
      set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      test_reset();
      test_contention();
      test_single();
      test_busy();
      test_x0();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
